// File: rtl/bus_bridge_master.sv
// -----------------------------------------------------------------------------
// bus_bridge_master
//
// Byte-serial bus initiator. Takes commands from a UART byte core, arbitrates
// for the io bus with bus_req/bus_gnt, performs one single-byte write or read,
// and returns one response byte per command.
//
// Command formats (bytes in order):
//   'W' (8'h57), ADDR_HI, ADDR_LO, DATA  -> write, response ACK_BYTE
//   'R' (8'h52), ADDR_HI, ADDR_LO        -> read,  response is the read byte
// Any other opcode byte, or an idle gap of TIMEOUT_CYCLES between command
// bytes, produces an err pulse and a NAK_BYTE response.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   rx_data/rx_valid  command byte stream (strobe, no backpressure)
//   tx_data/tx_valid  response byte, held until tx_ready
//   tx_ready          byte core accepts the response
//   bus_req/bus_gnt   bus request to / grant from the CPU arbiter
//   address           16-bit bus address (0 while the bus is not held)
//   bus_wdata         write data to io din (0 while the bus is not held)
//   bus_rdata         read data from io dout
//   w_en/r_en         single-cycle write / read strobes
//   busy              high in any state other than IDLE
//   err               one-cycle pulse on illegal opcode or timeout
// -----------------------------------------------------------------------------
module bus_bridge_master #(
  parameter int unsigned READ_LATENCY   = 1,        // 1..3
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] address,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        w_en,
  output logic        r_en,
  output logic        busy,
  output logic        err
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_GET_AH  = 4'd1;
  localparam logic [3:0] S_GET_AL  = 4'd2;
  localparam logic [3:0] S_GET_D   = 4'd3;
  localparam logic [3:0] S_REQ     = 4'd4;
  localparam logic [3:0] S_ACCESS  = 4'd5;
  localparam logic [3:0] S_RWAIT   = 4'd6;
  localparam logic [3:0] S_RELEASE = 4'd7;
  localparam logic [3:0] S_RESP    = 4'd8;

  localparam logic [7:0]  OP_WRITE = 8'h57;
  localparam logic [7:0]  OP_READ  = 8'h52;

  // Expiry is detected when the gap counter reaches its last value.
  localparam logic [15:0] TO_LAST  = TIMEOUT_CYCLES - 16'd1;
  localparam logic [1:0]  LAT      = 2'(READ_LATENCY);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  logic [3:0]  state;
  logic [3:0]  state_nx;
  logic        is_write;     // latched opcode: 1 = 'W', 0 = 'R'
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic [7:0]  rdata_q;
  logic [15:0] to_cnt;       // idle gap between command bytes
  logic [1:0]  lat_cnt;      // cycles elapsed since the r_en cycle
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;
  logic        err_q;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic in_get;
  logic timeout_hit;
  logic opcode_ok;
  logic take_op;
  logic illegal_op;
  logic tx_fire;
  logic bus_drive;
  logic lat_done;

  assign in_get      = (state == S_GET_AH) || (state == S_GET_AL) ||
                       (state == S_GET_D);
  assign timeout_hit = in_get && (to_cnt == TO_LAST);
  assign opcode_ok   = (rx_data == OP_WRITE) || (rx_data == OP_READ);
  // A pending NAK (tx_valid in IDLE) blocks new commands until accepted.
  assign take_op     = (state == S_IDLE) && rx_valid && !tx_valid_q;
  assign illegal_op  = take_op && !opcode_ok;
  assign tx_fire     = tx_valid_q && tx_ready;
  assign bus_drive   = (state == S_ACCESS) || (state == S_RWAIT);
  assign lat_done    = (state == S_RWAIT) && (lat_cnt == LAT);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred for state_nx.
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (take_op && opcode_ok) state_nx = S_GET_AH;
      end
      S_GET_AH: begin
        // Timeout has priority over a byte arriving in the same cycle.
        if (timeout_hit)   state_nx = S_IDLE;
        else if (rx_valid) state_nx = S_GET_AL;
      end
      S_GET_AL: begin
        if (timeout_hit)   state_nx = S_IDLE;
        else if (rx_valid) state_nx = is_write ? S_GET_D : S_REQ;
      end
      S_GET_D: begin
        if (timeout_hit)   state_nx = S_IDLE;
        else if (rx_valid) state_nx = S_REQ;
      end
      S_REQ: begin
        // No timeout while waiting for the arbiter.
        if (bus_gnt) state_nx = S_ACCESS;
      end
      S_ACCESS: begin
        // A grant drop from here on is a protocol violation; we complete.
        state_nx = is_write ? S_RELEASE : S_RWAIT;
      end
      S_RWAIT: begin
        if (lat_done) state_nx = S_RELEASE;
      end
      S_RELEASE: begin
        state_nx = S_RESP;
      end
      S_RESP: begin
        if (tx_fire) state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Command field capture. Fields are cleared when a new opcode is taken and
  // on timeout, so a partially received command never leaks into the next.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_write <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else if (timeout_hit) begin
      addr_q   <= '0;
      data_q   <= '0;
    end else if (take_op && opcode_ok) begin
      is_write <= (rx_data == OP_WRITE);
      addr_q   <= '0;
      data_q   <= '0;
    end else if (rx_valid) begin
      case (state)
        S_GET_AH: addr_q[15:8] <= rx_data;
        S_GET_AL: addr_q[7:0]  <= rx_data;
        S_GET_D:  data_q       <= rx_data;
        default:  ;  // bytes outside the receive states are dropped
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Inter-byte timeout counter: cleared by every received byte and whenever
  // no command is being collected.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (rx_valid || !in_get || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read latency: lat_cnt is 1 in the first RWAIT cycle, and bus_rdata is
  // captured in the RWAIT cycle where it equals READ_LATENCY.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
      rdata_q <= '0;
    end else begin
      if (state == S_ACCESS) begin
        lat_cnt <= 2'd1;
      end else if (state == S_RWAIT && !lat_done) begin
        lat_cnt <= lat_cnt + 2'd1;
      end
      if (lat_done) begin
        rdata_q <= bus_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response byte and error pulse. The NAK path only ever starts from IDLE or
  // a receive state, so it can never overlap a held bus.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= illegal_op || timeout_hit;
      if (state == S_RELEASE) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= is_write ? ACK_BYTE : rdata_q;
      end else if (illegal_op || timeout_hit) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= NAK_BYTE;
      end else if (tx_fire) begin
        tx_valid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Bus signals decode straight from the state register, so an
  // asynchronous reset drops bus_req and the strobes immediately.
  // ---------------------------------------------------------------------------
  assign bus_req   = (state == S_REQ) || bus_drive;
  assign address   = bus_drive ? addr_q : 16'h0000;
  assign bus_wdata = (bus_drive && is_write) ? data_q : 8'h00;
  assign w_en      = (state == S_ACCESS) &&  is_write;
  assign r_en      = (state == S_ACCESS) && !is_write;
  assign busy      = (state != S_IDLE);
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign err       = err_q;

endmodule

// File: doc/bus_bridge_master.md
Name: bus_bridge_master

Overview:
- Bus initiator that sits in front of the io decoder and drives its din/address/w_en/r_en bus, alongside the CPU.
- Accepts a byte-serial command stream from an external UART byte core and arbitrates for the bus via req/grant.
- Issues single-byte writes or reads to io registers or VRAM, and returns one response byte per command on a byte-out handshake.
- Provides a debug/bring-up path into every peripheral without CPU firmware.

Parameters:
- READ_LATENCY, 1: cycles from r_en assertion to valid bus_rdata; legal range 1-3.
- TIMEOUT_CYCLES, 16'd50000: maximum idle gap between bytes of one command before it is aborted.
- ACK_BYTE, 8'h06: response byte sent after a completed write.
- NAK_BYTE, 8'h15: response byte sent for an aborted command or an illegal opcode.

Ports:
- clk, input, 1: system clock (single domain).
- rst_n, input, 1: asynchronous, active-low reset.
- rx_data, input, 8: command byte from the UART byte core.
- rx_valid, input, 1: one-cycle strobe; rx_data is valid this cycle (no backpressure).
- tx_data, output, 8: response byte.
- tx_valid, output, 1: response byte valid; held until tx_ready.
- tx_ready, input, 1: byte core accepts tx_data when tx_valid and tx_ready are both high.
- bus_req, output, 1: bus request to the CPU arbiter.
- bus_gnt, input, 1: bus granted; the CPU tristates/muxes away while high.
- address, output, 16: bus address.
- bus_wdata, output, 8: write data, connects to io din.
- bus_rdata, input, 8: read data, connects from io dout.
- w_en, output, 1: single-cycle write strobe.
- r_en, output, 1: single-cycle read strobe.
- busy, output, 1: high in any state other than IDLE.
- err, output, 1: one-cycle pulse on illegal opcode or timeout.

Behaviour:
- Reset values: all outputs 0; state = IDLE; timeout counter = 0.
- Command formats:
  - 'W' (8'h57): ADDR_HI, ADDR_LO, DATA -> write; response ACK_BYTE.
  - 'R' (8'h52): ADDR_HI, ADDR_LO -> read; response is the read byte.
- States:
  - IDLE -> GET_AH on rx_valid with 'W' or 'R' (opcode latched). Any other byte: err pulse, NAK queued, stay in IDLE.
  - GET_AH -> GET_AL -> (W: GET_D | R: REQ). Each transition occurs on rx_valid; the byte is latched.
  - GET_D -> REQ on rx_valid.
  - REQ: bus_req = 1. Wait for bus_gnt; no timeout applies in this state.
    - The cycle after bus_gnt is seen high, go to ACCESS.
  - ACCESS: address/bus_wdata driven; w_en or r_en = 1 for exactly one cycle.
    - W: go to RELEASE.
    - R: go to RWAIT.
  - RWAIT: count READ_LATENCY cycles after the r_en cycle, then capture bus_rdata and go to RELEASE.
  - RELEASE: bus_req = 0; load tx_data; go to RESP.
  - RESP: tx_valid = 1 until tx_ready; then go to IDLE.
- Bus signal rules:
  - bus_req rises in REQ and stays high through ACCESS/RWAIT; it drops in RELEASE.
  - address, bus_wdata, w_en and r_en are 0 whenever bus_req is 0.
  - address and bus_wdata stay stable from ACCESS through RWAIT.
- bus_gnt dropping during ACCESS/RWAIT is a protocol violation; the block ignores it and completes.
- Timeout: the counter clears on every rx_valid and increments in GET_AH/GET_AL/GET_D. At TIMEOUT_CYCLES-1 -> err pulse, NAK queued, go to IDLE; partially latched fields are discarded.
- rx_valid during REQ..RESP: the byte is dropped (no error). rx_valid in the same cycle the timeout fires: timeout wins, and the byte is dropped.
- NAK path:
  - From IDLE or a timeout: tx_valid with NAK_BYTE. New rx bytes are dropped until the NAK is accepted.
  - A NAK is never issued while the bus is held.
- Address is a full 16 bits; no auto-increment; writes to 0x2000-0x2960 reach VRAM unchanged.
- Reset mid-operation: immediate return to IDLE; bus_req, w_en, r_en and tx_valid are deasserted asynchronously.

Test Plan:
- Write: rx 57,00,0A,41; bus_gnt tied 1 -> one w_en cycle with address=0x000A, bus_wdata=0x41; then tx_data=0x06, tx_valid held until tx_ready.
- Read with latency: READ_LATENCY=2; rx 52,00,03; bus_rdata=0x5A -> one r_en cycle at 0x0003; data captured 2 cycles later; tx_data=0x5A.
- Grant delay: hold bus_gnt=0 for 100 cycles after the command -> bus_req steady high, no strobes; access occurs 1 cycle after the grant; no timeout.
- Illegal opcode: rx 0x33 -> err pulse, tx NAK 0x15, bus_req never asserted.
- Timeout: TIMEOUT_CYCLES=20; rx 57,20 then silence -> err at the 20th idle cycle, NAK sent; a following rx 52,20,00 completes a normal read of 0x2000.
- Reset: assert rst_n low during RWAIT -> bus_req/r_en/tx_valid are 0 immediately; after release, busy=0 and a new command completes.
